// File: rtl/mem_access_unit.sv
// MEM-stage controller: word loads/stores over req/ack, branch resolve, MEM/WB register.
// Optional MEM_ALIGN_CHECK_EN: misaligned accesses fault instead of issuing a request.
//
// state | meaning
// IDLE  | no access outstanding; EX/MEM contents are consumed or issued
// REQ   | request presented to data memory, waiting for dmem_ack
module mem_access_unit (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] alu_res,
  input  logic [31:0] reg_data2,
  input  logic [4:0]  rd,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic        branch,
  input  logic        memtoReg,
  input  logic        regWrite,
  input  logic        alu_zero,
  input  logic        qed_vld,
  input  logic [31:0] pc_branch,
  output logic        ex_mem_write,
  output logic        pc_src,
  output logic [31:0] pc_target,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_rd,
  output logic        wb_regWrite,
  output logic        wb_vld,
  output logic        align_err
);

  typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_t;

  state_t      state_q, state_d;
  logic        dmem_req_q, dmem_req_d;
  logic        dmem_we_q, dmem_we_d;
  logic [31:0] dmem_addr_q, dmem_addr_d;
  logic [31:0] dmem_wdata_q, dmem_wdata_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic        wb_regWrite_q, wb_regWrite_d;
  logic        wb_vld_q, wb_vld_d;
  logic        align_err_q, align_err_d;

  logic mem_op;
  logic misalign;

  assign mem_op = memRead | memWrite;

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign = (alu_res[1:0] != 2'b00);
`else
  // Without the check the low address bits are simply dropped; align_err_q stays 0.
  assign misalign = 1'b0;
`endif

  assign pc_src    = branch & alu_zero;
  assign pc_target = pc_branch;

  always_comb begin
    state_d       = state_q;
    dmem_req_d    = dmem_req_q;
    dmem_we_d     = dmem_we_q;
    dmem_addr_d   = dmem_addr_q;
    dmem_wdata_d  = dmem_wdata_q;
    wb_data_d     = wb_data_q;
    wb_rd_d       = wb_rd_q;
    wb_regWrite_d = 1'b0;
    wb_vld_d      = 1'b0;
    align_err_d   = 1'b0;
    ex_mem_write  = 1'b1;

    case (state_q)
      IDLE: begin
        if (mem_op && !misalign) begin
          ex_mem_write = 1'b0;
          state_d      = REQ;
          dmem_req_d   = 1'b1;
          dmem_we_d    = memWrite;
          dmem_addr_d  = {alu_res[31:2], 2'b00};
          dmem_wdata_d = reg_data2;
        end else if (mem_op) begin
          // Faulting access retires with the address as data and no register write.
          align_err_d = 1'b1;
          wb_data_d   = alu_res;
          wb_rd_d     = rd;
          wb_vld_d    = qed_vld;
        end else begin
          wb_data_d     = alu_res;
          wb_rd_d       = rd;
          wb_regWrite_d = regWrite;
          wb_vld_d      = qed_vld;
        end
      end
      REQ: begin
        if (dmem_ack) begin
          state_d       = IDLE;
          dmem_req_d    = 1'b0;
          dmem_we_d     = 1'b0;
          wb_data_d     = memtoReg ? dmem_rdata : alu_res;
          wb_rd_d       = rd;
          wb_regWrite_d = regWrite;
          wb_vld_d      = qed_vld;
        end else begin
          ex_mem_write = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      dmem_req_q    <= 1'b0;
      dmem_we_q     <= 1'b0;
      dmem_addr_q   <= 32'd0;
      dmem_wdata_q  <= 32'd0;
      wb_data_q     <= 32'd0;
      wb_rd_q       <= 5'd0;
      wb_regWrite_q <= 1'b0;
      wb_vld_q      <= 1'b0;
      align_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      dmem_req_q    <= dmem_req_d;
      dmem_we_q     <= dmem_we_d;
      dmem_addr_q   <= dmem_addr_d;
      dmem_wdata_q  <= dmem_wdata_d;
      wb_data_q     <= wb_data_d;
      wb_rd_q       <= wb_rd_d;
      wb_regWrite_q <= wb_regWrite_d;
      wb_vld_q      <= wb_vld_d;
      align_err_q   <= align_err_d;
    end
  end

  assign dmem_req    = dmem_req_q;
  assign dmem_we     = dmem_we_q;
  assign dmem_addr   = dmem_addr_q;
  assign dmem_wdata  = dmem_wdata_q;
  assign wb_data     = wb_data_q;
  assign wb_rd       = wb_rd_q;
  assign wb_regWrite = wb_regWrite_q;
  assign wb_vld      = wb_vld_q;
  assign align_err   = align_err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: transaction-level reference checked every cycle plus directed literal checks.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] alu_res, reg_data2, pc_branch, dmem_rdata;
  logic [4:0]  rd;
  logic        memRead, memWrite, branch, memtoReg, regWrite, alu_zero, qed_vld, dmem_ack;
  logic        ex_mem_write, pc_src, dmem_req, dmem_we, wb_regWrite, wb_vld, align_err;
  logic [31:0] pc_target, dmem_addr, dmem_wdata, wb_data;
  logic [4:0]  wb_rd;

  int checks = 0;
  int errors = 0;

  mem_access_unit dut (
    .clk(clk), .reset_n(reset_n), .alu_res(alu_res), .reg_data2(reg_data2), .rd(rd),
    .memRead(memRead), .memWrite(memWrite), .branch(branch), .memtoReg(memtoReg),
    .regWrite(regWrite), .alu_zero(alu_zero), .qed_vld(qed_vld), .pc_branch(pc_branch),
    .ex_mem_write(ex_mem_write), .pc_src(pc_src), .pc_target(pc_target),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .wb_data(wb_data), .wb_rd(wb_rd),
    .wb_regWrite(wb_regWrite), .wb_vld(wb_vld), .align_err(align_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: an access is either outstanding or not; the MEM/WB record is what retired last.
  bit          m_busy;
  logic        m_req, m_we, m_wb_rw, m_wb_vld, m_align;
  logic [31:0] m_addr, m_wdata, m_wb_data;
  logic [4:0]  m_wb_rd;
  bit          align_on;

  initial begin
    align_on = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
    align_on = 1'b1;
`endif
  end

  function automatic bit faults(input logic [31:0] a, input logic op);
    return align_on && op && (a % 4 != 0);
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_busy = 0; m_req = 0; m_we = 0; m_addr = 0; m_wdata = 0;
      m_wb_data = 0; m_wb_rd = 0; m_wb_rw = 0; m_wb_vld = 0; m_align = 0;
    end else begin
      m_align = 0;
      if (m_busy && dmem_ack) begin
        m_busy = 0; m_req = 0; m_we = 0;
        m_wb_data = memtoReg ? dmem_rdata : alu_res;
        m_wb_rd = rd; m_wb_rw = regWrite; m_wb_vld = qed_vld;
      end else if (m_busy) begin
        m_wb_rw = 0; m_wb_vld = 0;
      end else if (faults(alu_res, memRead | memWrite)) begin
        m_align = 1;
        m_wb_data = alu_res; m_wb_rd = rd; m_wb_rw = 0; m_wb_vld = qed_vld;
      end else if (memRead | memWrite) begin
        m_busy = 1; m_req = 1; m_we = memWrite;
        m_addr = alu_res - (alu_res % 4); m_wdata = reg_data2;
        m_wb_rw = 0; m_wb_vld = 0;
      end else begin
        m_wb_data = alu_res; m_wb_rd = rd; m_wb_rw = regWrite; m_wb_vld = qed_vld;
      end
    end
  end

  function automatic logic exp_ex_mem_write();
    if (m_busy) return dmem_ack;
    if ((memRead | memWrite) && !faults(alu_res, 1'b1)) return 1'b0;
    return 1'b1;
  endfunction

  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      chk("cmp_ex_mem_write", ex_mem_write, exp_ex_mem_write());
      chk("cmp_pc_src", pc_src, branch & alu_zero);
      chk("cmp_pc_target", pc_target, pc_branch);
      chk("cmp_dmem_req", dmem_req, m_req);
      chk("cmp_dmem_we", dmem_we, m_we);
      chk("cmp_dmem_addr", dmem_addr, m_addr);
      chk("cmp_dmem_wdata", dmem_wdata, m_wdata);
      chk("cmp_wb_data", wb_data, m_wb_data);
      chk("cmp_wb_rd", wb_rd, m_wb_rd);
      chk("cmp_wb_regWrite", wb_regWrite, m_wb_rw);
      chk("cmp_wb_vld", wb_vld, m_wb_vld);
      chk("cmp_align_err", align_err, m_align);
    end
  end

  task automatic idle_in();
    alu_res = 0; reg_data2 = 0; rd = 0; memRead = 0; memWrite = 0; branch = 0;
    memtoReg = 0; regWrite = 0; alu_zero = 0; qed_vld = 0; pc_branch = 0;
    dmem_rdata = 0; dmem_ack = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int low_cnt;

  initial begin
    idle_in();
    reset_n = 1'b0;
    step(); step();
    chk("rst_dmem_req", dmem_req, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_align_err", align_err, 0);
    reset_n = 1'b1;

    // ALU op, with a stray ack that must be ignored in IDLE
    alu_res = 32'h1234; rd = 5; regWrite = 1; qed_vld = 1; dmem_ack = 1;
    #1 chk("alu_ex_mem_write", ex_mem_write, 1);
    step(); idle_in();
    chk("alu_wb_data", wb_data, 32'h1234);
    chk("alu_wb_rd", wb_rd, 5);
    chk("alu_wb_regWrite", wb_regWrite, 1);
    chk("alu_no_req", dmem_req, 0);

    // Load with three wait cycles
    low_cnt = 0;
    alu_res = 32'h100; memRead = 1; memtoReg = 1; regWrite = 1; rd = 7; qed_vld = 1;
    #1 if (!ex_mem_write) low_cnt++;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("ld_req", dmem_req, 1);
      chk("ld_addr", dmem_addr, 32'h100);
      chk("ld_bubble", wb_regWrite, 0);
      if (!ex_mem_write) low_cnt++;
    end
    dmem_ack = 1; dmem_rdata = 32'hDEADBEEF;
    #1 chk("ld_ack_ex_mem_write", ex_mem_write, 1);
    step(); idle_in();
    chk("ld_stall_cycles", low_cnt, 4);
    chk("ld_wb_data", wb_data, 32'hDEADBEEF);
    chk("ld_wb_rd", wb_rd, 7);
    chk("ld_req_drop", dmem_req, 0);

    // Zero-wait store
    alu_res = 32'h204; reg_data2 = 32'hA5A5A5A5; memWrite = 1; rd = 3; qed_vld = 1;
    #1 chk("st_stall", ex_mem_write, 0);
    step();
    dmem_ack = 1;
    #1 chk("st_we", dmem_we, 1);
    chk("st_wdata", dmem_wdata, 32'hA5A5A5A5);
    chk("st_addr", dmem_addr, 32'h204);
    chk("st_ack_ex_mem_write", ex_mem_write, 1);
    step(); idle_in();
    chk("st_wb_regWrite", wb_regWrite, 0);
    chk("st_wb_vld", wb_vld, 1);

    // Read+write together is a write; one wait cycle
    alu_res = 32'h308; reg_data2 = 32'h0BADF00D; memRead = 1; memWrite = 1; regWrite = 1; rd = 9;
    step(); step();
    chk("rw_we", dmem_we, 1);
    dmem_ack = 1; dmem_rdata = 32'h11111111;
    step(); idle_in();

    // Branch resolve
    branch = 1; alu_zero = 1; pc_branch = 32'h80;
    #1 chk("br_taken", pc_src, 1);
    chk("br_target", pc_target, 32'h80);
    alu_zero = 0;
    #1 chk("br_not_taken", pc_src, 0);
    step(); idle_in();

    // Misaligned load at 0x102
    alu_res = 32'h102; memRead = 1; regWrite = 1; rd = 4; qed_vld = 1;
`ifdef MEM_ALIGN_CHECK_EN
    #1 chk("mis_ex_mem_write", ex_mem_write, 1);
    step(); idle_in();
    chk("mis_align_err", align_err, 1);
    chk("mis_wb_data", wb_data, 32'h102);
    chk("mis_wb_regWrite", wb_regWrite, 0);
    chk("mis_no_req", dmem_req, 0);
    step();
    chk("mis_pulse_end", align_err, 0);
`else
    step();
    chk("mis_addr", dmem_addr, 32'h100);
    chk("mis_align_err", align_err, 0);
    dmem_ack = 1;
    step(); idle_in();
`endif

    // Async reset mid-access with ack pending
    alu_res = 32'h440; memRead = 1; memtoReg = 1; regWrite = 1; rd = 2;
    step();
    chk("mid_req", dmem_req, 1);
    #2 reset_n = 1'b0; dmem_ack = 1;
    #1 chk("mid_rst_req", dmem_req, 0);
    chk("mid_rst_addr", dmem_addr, 0);
    chk("mid_rst_wb_data", wb_data, 0);
    chk("mid_rst_wb_rd", wb_rd, 0);
    chk("mid_rst_wb_vld", wb_vld, 0);
    step();
    idle_in();
    alu_res = 32'h55; rd = 6; regWrite = 1; dmem_ack = 1;
    reset_n = 1'b1;
    #1 chk("post_rst_ex_mem_write", ex_mem_write, 1);
    step(); idle_in();
    chk("post_rst_wb_data", wb_data, 32'h55);
    chk("post_rst_no_req", dmem_req, 0);
    step(); step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

MEM-stage controller sitting downstream of the EX/MEM pipeline register: consumes its outputs, performs word loads/stores to data memory over a req/ack handshake, and resolves branches. It produces the registered MEM/WB stage values. It back-pressures EX/MEM through that register's write enable while an access is outstanding.

## Interface
- No parameters. Data width 32, register index width 5.
- `clk`  in  1  rising-edge clock
- `reset_n`  in  1  asynchronous, active-low reset
- `alu_res`  in  32  memory address, or ALU result for non-memory instructions
- `reg_data2`  in  32  store data
- `rd`  in  5  destination register
- `memRead`, `memWrite`, `branch`, `memtoReg`, `regWrite`, `alu_zero`, `qed_vld`  in  1 each  EX/MEM control and status bits
- `pc_branch`  in  32  branch target
- `ex_mem_write`  out  1  write enable to EX/MEM; 0 = hold/stall
- `pc_src`  out  1  taken-branch select, combinational
- `pc_target`  out  32  equals `pc_branch`, combinational
- `dmem_req`, `dmem_we`  out  1 each  memory request / write strobe (registered)
- `dmem_addr`, `dmem_wdata`  out  32 each  registered request fields
- `dmem_rdata`  in  32  load data, valid while `dmem_ack`=1
- `dmem_ack`  in  1  access complete
- `wb_data`  out  32  MEM/WB result
- `wb_rd`  out  5  MEM/WB destination
- `wb_regWrite`, `wb_vld`  out  1 each  MEM/WB write enable / QED valid
- `align_err`  out  1  misaligned-access pulse (see Configuration)

## Operation
- `mem_op` = `memRead | memWrite`. If both are set, the access is treated as a write.
- FSM states: IDLE, REQ.
- IDLE, `mem_op`=0:
  - `ex_mem_write`=1.
  - Next edge loads `wb_data`=`alu_res`, `wb_rd`=`rd`, `wb_regWrite`=`regWrite`, `wb_vld`=`qed_vld`.
- IDLE, `mem_op`=1:
  - `ex_mem_write`=0.
  - Next edge: go to REQ; `dmem_req`=1; `dmem_we`=`memWrite`; `dmem_addr`={`alu_res`[31:2],2'b00}; `dmem_wdata`=`reg_data2`.
  - MEM/WB loads a bubble: `wb_regWrite`=0, `wb_vld`=0, `wb_rd`/`wb_data` unchanged.
- REQ, `dmem_ack`=0:
  - Request fields are held stable; `ex_mem_write`=0.
  - MEM/WB loads a bubble each cycle.
- REQ, `dmem_ack`=1:
  - `ex_mem_write`=1, so EX/MEM advances on the same edge.
  - Next edge: `dmem_req`=0; `dmem_we`=0; state → IDLE.
  - MEM/WB loads `wb_data`=`memtoReg` ? `dmem_rdata` : `alu_res`; `wb_rd`=`rd`; `wb_regWrite`=`regWrite`; `wb_vld`=`qed_vld`.
- `pc_src`=`branch & alu_zero`, independent of state. Redirect and flush are handled upstream.
- Back-to-back memory ops: the next op is seen in IDLE the cycle after completion. There is no issue in the ack cycle.

## Timing
- Reset (async, any state, including mid-access):
  - state=IDLE.
  - `dmem_req`=0, `dmem_we`=0, `dmem_addr`=0, `dmem_wdata`=0.
  - `wb_data`=0, `wb_rd`=0, `wb_regWrite`=0, `wb_vld`=0, `align_err`=0.
  - Any outstanding ack is ignored after reset.
- Non-memory latency: 1 cycle from EX/MEM to MEM/WB.
- Memory latency: 1 cycle to request + N cycles to ack + 1 cycle to MEM/WB.
  - Zero-wait memory (ack in the first REQ cycle) gives a 2-cycle op with 1 stall cycle.
- `dmem_req` never drops without ack. `dmem_addr`, `dmem_we` and `dmem_wdata` never change while `dmem_req`=1 and `dmem_ack`=0.
- `dmem_ack` is ignored in IDLE.

## Configuration
- `MEM_ALIGN_CHECK_EN` defined:
  - In IDLE, a `mem_op` with `alu_res`[1:0]≠0 does not enter REQ.
  - `ex_mem_write`=1 and there is no memory request.
  - Next edge: `align_err`=1 for exactly one cycle; MEM/WB loads `wb_rd`=`rd`, `wb_regWrite`=0, `wb_vld`=`qed_vld`, `wb_data`=`alu_res` (faulting address).
- `MEM_ALIGN_CHECK_EN` undefined:
  - Address bits [1:0] are ignored (the access is forced word-aligned).
  - `align_err` is tied to 0.

## Test plan
- Reset: assert `reset_n`=0 mid-REQ with `dmem_req`=1 → all outputs go to their reset values immediately, without waiting for `clk`; after release, state is IDLE.
- ALU op `alu_res`=0x1234, `rd`=5, `regWrite`=1 → next cycle `wb_data`=0x1234, `wb_rd`=5, `wb_regWrite`=1; `ex_mem_write` stays 1.
- Load `alu_res`=0x100, `memRead`=`memtoReg`=1, ack after 3 REQ cycles with `dmem_rdata`=0xDEADBEEF → `ex_mem_write` low for 4 cycles; `dmem_addr`=0x100 held throughout; `wb_data`=0xDEADBEEF; one bubble per stall cycle.
- Store `alu_res`=0x204, `reg_data2`=0xA5A5A5A5, ack in the first REQ cycle → `dmem_we`=1, `dmem_wdata`=0xA5A5A5A5, 1 stall cycle, `wb_regWrite`=0.
- Branch `branch`=1, `alu_zero`=1, `pc_branch`=0x80 → `pc_src`=1, `pc_target`=0x80 in the same cycle; with `alu_zero`=0 → `pc_src`=0.
- `MEM_ALIGN_CHECK_EN`: load at 0x102 → no `dmem_req`, `align_err` pulses for 1 cycle, `wb_data`=0x102, `wb_regWrite`=0. Without the macro: `dmem_addr`=0x100.
